act_lut_loader: RTL and testbench
=================================

Name: act_lut_loader

Overview:
- Writer/programming side of the piecewise-linear activation LUT used by the per-neuron activation function blocks (tanh, sigmoid).
- Accepts a stream of breakpoint samples over a valid/ready handshake and stores them in a 16-entry table plus one top-endpoint register.
- Serves the lookup read port: given the segment address (activation input bits [7:4]), it returns base and next_data with 1-cycle registered latency, ready for the interpolator.
- Allows the activation table to be reloaded at run time instead of being fixed as constants.

Parameters:
WIDTH, 8, data width of table entries and of base/next_data (signed)
ADDR_W, 4, segment address width; table depth = 2**ADDR_W

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
load_start  input  1  pulse; begins a table load
cfg_valid  input  1  cfg_data valid
cfg_ready  output  1  loader accepts cfg_data this cycle
cfg_data  input  WIDTH  signed breakpoint sample
cfg_last  input  1  marks final sample of load
table_valid  output  1  table fully loaded and consistent
load_err  output  1  sticky; last load was malformed
rd_en  input  1  lookup request
address  input  ADDR_W  segment address (z[7:4])
rd_valid  output  1  base/next_data valid (1 cycle after rd_en)
base  output  WIDTH  signed table value at segment start
next_data  output  WIDTH  signed table value at segment end

Behaviour:
- Reset: FSM in IDLE; cfg_ready=0; table_valid=0; load_err=0; rd_valid=0; base=0; next_data=0; all entries and the endpoint register cleared to 0.
- FSM states:
  - IDLE: load_start -> LOAD, with cnt=0 and load_err cleared.
  - LOAD: cfg_ready=1. Each handshake (cfg_valid & cfg_ready) stores cfg_data and increments cnt.
    - cnt 0..15 write entry[cnt]; cnt 16 writes endpoint.
    - Handshake at cnt=16 with cfg_last=1 -> DONE.
    - cfg_last=1 at cnt<16, or cfg_last=0 at cnt=16 -> load_err=1, then IDLE.
  - DONE: table_valid=1, cfg_ready=0. load_start -> LOAD.
- Sample order: entry[k] is the function value at z = k*16 interpreted with two's-complement wrap, i.e. k=0..7 cover z=0..112 and k=8..15 cover z=-128..-16. The endpoint is the value at z=+128, saturated.
- Lookup (a is address, sampled when rd_en=1; results available next cycle with rd_valid=1):
  - base = entry[a].
  - next_data = endpoint when a=7; otherwise entry[(a+1) mod 16]. Address 15 wraps to entry[0] (z=-1 -> 0).
  - rd_valid=0 in cycles with no rd_en; base/next_data hold their last value.
- Lookups are serviced in every state. During LOAD they return partially written contents; consumers gate on table_valid.
- table_valid drops to 0 in the cycle after load_start is accepted. It stays 0 until the next successful load completes.
- load_start while in LOAD: ignored.
- Back-to-back handshakes, one per cycle: supported.
- rst asserted mid-load: full reset, table cleared, and table_valid=0.
- Simultaneous rd_en and a write to the same entry: read returns the old value (read-before-write).
- No arithmetic is performed. Values are stored and returned bit-exact as signed WIDTH.

Test Plan:
- Reset, then rd_en with address=5 -> rd_valid=1 next cycle; base=0, next_data=0, table_valid=0.
- load_start, then stream entry[k]=k+1 for k=0..15, endpoint=100 with cfg_last on sample 17, one per cycle -> table_valid=1 one cycle after the final handshake, cfg_ready=0.
- After that load: address=3 -> base=4, next_data=5; address=7 -> base=8, next_data=100; address=15 -> base=16, next_data=1.
- Load with cfg_valid toggling 1/0 and cfg_last asserted on sample 10 -> load_err=1, FSM back to IDLE, table_valid=0, cfg_ready=0.
- Load 17 samples without cfg_last -> load_err=1. Then a correct reload with entry[k]=-k -> load_err=0 at load_start, table_valid=1; address=9 -> base=-9, next_data=-10.
- Assert rst after 6 samples of a load -> all outputs at reset values; address=2 reads base=0, next_data=0.

Source files
------------

// File: rtl/act_lut_loader.sv
// Programming side of the piecewise-linear activation LUT: streams breakpoints into a
// 16-entry table plus top endpoint and serves the interpolator's base/next_data read port.
module act_lut_loader #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic signed [WIDTH-1:0]  cfg_data,
    input  logic                     cfg_last,
    output logic                     table_valid,
    output logic                     load_err,
    input  logic                     rd_en,
    input  logic        [ADDR_W-1:0] address,
    output logic                     rd_valid,
    output logic signed [WIDTH-1:0]  base,
    output logic signed [WIDTH-1:0]  next_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  END_IDX  = CNT_W'(DEPTH);
    // Last segment before the z wrap point; its upper end is the endpoint register.
    localparam logic [ADDR_W-1:0] TOP_SEG  = ADDR_W'(DEPTH / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         cnt, cnt_next;
    logic                     err_next;
    logic                     wr_entry, wr_end;
    logic signed [WIDTH-1:0]  entry [DEPTH];
    logic signed [WIDTH-1:0]  endpoint;
    logic [ADDR_W-1:0]        addr_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            load_err <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples
            // the pre-edge values; blocking here would create order-dependent races.
            state    <= state_next;
            cnt      <= cnt_next;
            load_err <= err_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave
        // a signal unassigned and infer a latch.
        state_next  = state;
        cnt_next    = cnt;
        err_next    = load_err;
        wr_entry    = 1'b0;
        wr_end      = 1'b0;
        cfg_ready   = 1'b0;
        table_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_next = S_LOAD;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                end
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == END_IDX) begin
                        wr_end = 1'b1;
                        if (cfg_last) begin
                            state_next = S_DONE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = S_IDLE;
                        end
                    end else begin
                        wr_entry = 1'b1;
                        if (cfg_last) begin
                            err_next   = 1'b1;
                            state_next = S_IDLE;
                        end
                    end
                end
            end
            S_DONE: begin
                table_valid = 1'b1;
                if (load_start) begin
                    state_next = S_LOAD;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is deliberately reset: lookups are legal before any load
            // and must return zeros, which rules out a plain RAM macro here.
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
            endpoint <= '0;
        end else begin
            if (wr_entry) begin
                entry[cnt[ADDR_W-1:0]] <= cfg_data;
            end
            if (wr_end) begin
                endpoint <= cfg_data;
            end
        end
    end

    assign addr_inc = address + ADDR_W'(1);

    // Reads see pre-edge table contents, giving read-before-write on a same-entry collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            base      <= '0;
            next_data <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                base      <= entry[address];
                next_data <= (address == TOP_SEG) ? endpoint : entry[addr_inc];
            end
        end
    end

endmodule

// File: tb/tb_act_lut_loader.sv
// Randomized self-checking bench for act_lut_loader against an array-based table model.
module tb_act_lut_loader;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic signed [7:0] cfg_data = '0;
    logic              cfg_last = 1'b0;
    logic              table_valid;
    logic              load_err;
    logic              rd_en = 1'b0;
    logic [3:0]        address = '0;
    logic              rd_valid;
    logic signed [7:0] base;
    logic signed [7:0] next_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: table contents and load status, updated by sample index.
    logic signed [7:0] m_tab [16];
    logic signed [7:0] m_end;
    bit                m_valid, m_err, m_loading;
    int                m_cnt;
    logic signed [7:0] stim [17];

    act_lut_loader #(.WIDTH(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .table_valid(table_valid),
        .load_err   (load_err),
        .rd_en      (rd_en),
        .address    (address),
        .rd_valid   (rd_valid),
        .base       (base),
        .next_data  (next_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tab[i] = '0;
        m_end     = '0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_loading = 1'b0;
        m_cnt     = 0;
    endtask

    function automatic logic signed [7:0] exp_base(input logic [3:0] a);
        return m_tab[a];
    endfunction

    function automatic logic signed [7:0] exp_next(input logic [3:0] a);
        logic [3:0] an;
        an = a + 4'd1;
        return (a == 4'd7) ? m_end : m_tab[an];
    endfunction

    task automatic lookup(input logic [3:0] a, output logic signed [7:0] b,
                          output logic signed [7:0] n, output logic v);
        rd_en   = 1'b1;
        address = a;
        step();
        rd_en = 1'b0;
        b = base;
        n = next_data;
        v = rd_valid;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        if (!m_loading) begin
            m_loading = 1'b1;
            m_cnt     = 0;
            m_err     = 1'b0;
            m_valid   = 1'b0;
        end
    endtask

    task automatic send(input logic signed [7:0] d, input bit last, output bit ok);
        int w;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = last;
        w = 0;
        while (!cfg_ready && w < 8) begin
            step();
            w++;
        end
        ok = cfg_ready;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: cfg_ready=%b, required 1 within 8 cycles", cfg_ready);
        end else begin
            step();
            if (m_cnt < 16) m_tab[m_cnt] = d;
            else m_end = d;
            if (m_cnt == 16) begin
                m_loading = 1'b0;
                if (last) m_valid = 1'b1;
                else m_err = 1'b1;
            end else if (last) begin
                m_loading = 1'b0;
                m_err     = 1'b1;
            end
            m_cnt++;
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    // gap_mode: 0 none, 1 idle cycle before every sample, 2 random idles / load_start pulses
    task automatic run_load(input int first, input int n, input int last_at, input int gap_mode);
        bit ok;
        for (int i = first; i < n; i++) begin
            if (gap_mode == 1) step();
            if (gap_mode == 2) begin
                case ($urandom_range(3))
                    1: step();
                    2: start_load();
                    default: ;
                endcase
            end
            send(stim[i], i == last_at, ok);
            if (!ok || !m_loading) break;
        end
    endtask

    task automatic test_reset();
        logic signed [7:0] b, n;
        logic v;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
        n_checks++;
        if ({cfg_ready, table_valid, load_err, rd_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: rdy/tv/err/rdv=%b, required 0000",
                     {cfg_ready, table_valid, load_err, rd_valid});
        end
        n_checks++;
        if (base !== 8'sd0 || next_data !== 8'sd0) begin
            n_fail++;
            $display("FAIL reset_data: base=%0d next=%0d, required 0 0", base, next_data);
        end
        lookup(4'd5, b, n, v);
        n_checks++;
        if (v !== 1'b1 || b !== 8'sd0 || n !== 8'sd0 || table_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read5: v=%b base=%0d next=%0d tv=%b, required 1 0 0 0",
                     v, b, n, table_valid);
        end
        step();
        n_checks++;
        if (rd_valid !== 1'b0 || base !== b) begin
            n_fail++;
            $display("FAIL read_idle_hold: rd_valid=%b base=%0d, required 0 %0d", rd_valid, base, b);
        end
    endtask

    task automatic test_good_load();
        logic signed [7:0] b, n;
        logic v;
        logic [3:0] addrs [3];
        addrs = '{4'd3, 4'd7, 4'd15};
        for (int k = 0; k < 16; k++) stim[k] = 8'(k + 1);
        stim[16] = 8'sd100;
        start_load();
        n_checks++;
        if (cfg_ready !== 1'b1 || table_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL good_load_enter: rdy=%b tv=%b, required 1 0", cfg_ready, table_valid);
        end
        run_load(0, 17, 16, 0);
        n_checks++;
        if (table_valid !== 1'b1 || cfg_ready !== 1'b0 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL good_load_done: tv=%b rdy=%b err=%b, required 1 0 0",
                     table_valid, cfg_ready, load_err);
        end
        foreach (addrs[i]) begin
            lookup(addrs[i], b, n, v);
            n_checks++;
            if (v !== 1'b1 || b !== exp_base(addrs[i]) || n !== exp_next(addrs[i])) begin
                n_fail++;
                $display("FAIL good_read a=%0d: v=%b base=%0d next=%0d, required 1 %0d %0d",
                         addrs[i], v, b, n, exp_base(addrs[i]), exp_next(addrs[i]));
            end
        end
    endtask

    task automatic test_err_early();
        for (int k = 0; k < 17; k++) stim[k] = 8'($urandom);
        start_load();
        run_load(0, 17, 9, 1);
        step();
        n_checks++;
        if (load_err !== 1'b1 || table_valid !== 1'b0 || cfg_ready !== 1'b0 || m_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_early: err=%b tv=%b rdy=%b, required 1 0 0",
                     load_err, table_valid, cfg_ready);
        end
    endtask

    task automatic test_err_no_last_and_reload();
        logic signed [7:0] b, n;
        logic v;
        for (int k = 0; k < 17; k++) stim[k] = 8'($urandom);
        start_load();
        run_load(0, 17, -1, 0);
        n_checks++;
        if (load_err !== 1'b1 || table_valid !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_last: err=%b tv=%b rdy=%b, required 1 0 0",
                     load_err, table_valid, cfg_ready);
        end
        for (int k = 0; k < 16; k++) stim[k] = 8'(-k);
        stim[16] = 8'($urandom);
        start_load();
        n_checks++;
        if (load_err !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_clear_err: err=%b rdy=%b, required 0 1", load_err, cfg_ready);
        end
        run_load(0, 17, 16, 0);
        n_checks++;
        if (table_valid !== 1'b1 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_done: tv=%b err=%b, required 1 0", table_valid, load_err);
        end
        lookup(4'd9, b, n, v);
        n_checks++;
        if (b !== -8'sd9 || n !== -8'sd10 || b !== exp_base(4'd9)) begin
            n_fail++;
            $display("FAIL reload_read9: base=%0d next=%0d, required -9 -10", b, n);
        end
    endtask

    task automatic test_read_before_write();
        logic signed [7:0] old_b, old_n;
        bit ok;
        for (int k = 0; k < 17; k++) stim[k] = 8'($urandom);
        old_b = exp_base(4'd0);
        old_n = exp_next(4'd0);
        start_load();
        n_checks++;
        if (table_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tv_drop_on_start: tv=%b, required 0", table_valid);
        end
        rd_en   = 1'b1;
        address = 4'd0;
        send(stim[0], 1'b0, ok);
        rd_en = 1'b0;
        n_checks++;
        if (base !== old_b || next_data !== old_n) begin
            n_fail++;
            $display("FAIL read_before_write: base=%0d next=%0d, required %0d %0d",
                     base, next_data, old_b, old_n);
        end
        run_load(1, 17, 16, 0);
        n_checks++;
        if (table_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rbw_load_done: tv=%b, required 1", table_valid);
        end
    endtask

    task automatic test_random();
        logic signed [7:0] b, n;
        logic v;
        logic [3:0] a;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 17; k++) stim[k] = 8'($urandom);
            start_load();
            run_load(0, 17, 16, 2);
            n_checks++;
            if (table_valid !== m_valid || load_err !== m_err || cfg_ready !== m_loading) begin
                n_fail++;
                $display("FAIL rand_status it=%0d: tv=%b err=%b rdy=%b, required %b %b %b",
                         it, table_valid, load_err, cfg_ready, m_valid, m_err, m_loading);
            end
            for (int r = 0; r < 16; r++) begin
                a = 4'($urandom_range(15));
                lookup(a, b, n, v);
                n_checks++;
                if (v !== 1'b1 || b !== exp_base(a) || n !== exp_next(a)) begin
                    n_fail++;
                    $display("FAIL rand_read it=%0d a=%0d: v=%b base=%0d next=%0d, required 1 %0d %0d",
                             it, a, v, b, n, exp_base(a), exp_next(a));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic signed [7:0] b, n;
        logic v;
        for (int k = 0; k < 17; k++) stim[k] = 8'($urandom_range(127, 1));
        start_load();
        run_load(0, 6, -1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        n_checks++;
        if ({cfg_ready, table_valid, load_err, rd_valid} !== 4'b0000 ||
            base !== 8'sd0 || next_data !== 8'sd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: rdy/tv/err/rdv=%b base=%0d next=%0d, required 0000 0 0",
                     {cfg_ready, table_valid, load_err, rd_valid}, base, next_data);
        end
        lookup(4'd2, b, n, v);
        n_checks++;
        if (v !== 1'b1 || b !== 8'sd0 || n !== 8'sd0) begin
            n_fail++;
            $display("FAIL mid_reset_read2: v=%b base=%0d next=%0d, required 1 0 0", v, b, n);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_good_load();
        test_err_early();
        test_err_no_last_and_reload();
        test_read_before_write();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
